// File: rtl/snn_soc_pkg.sv
// Shared types and sizing constants for the SNN job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_soc_pkg;

  localparam int MAX_SPIKES    = 16;
  localparam int SEQ_TIMEOUT_W = 20;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_DMA_KICK,
    S_DMA_WAIT,
    S_CIM_KICK,
    S_CIM_WAIT,
    S_POP,
    S_CAP,
    S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVF     = 2'd3
  } seq_err_e;

endpackage

// File: rtl/snn_job_seq_watchdog.sv
// Per-phase watchdog: counts enabled cycles from a clear, flags when the limit is reached.
// Latency: expired is combinational from the registered count (limit 0 never expires).
// Backpressure: none; count saturates at all-ones.
module seq_watchdog #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over enable, hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/snn_job_seq.sv
// Job sequencer: DMA input planes, kick CIM inference, drain spike FIFO into the result buffer.
// Latency: start->dma_start 3 cycles; FIFO drain 2 cycles/entry; done 2 cycles after the last phase ends.
// Backpressure: waits on dma_done/cim_done/fifo_empty; optional job_cycles counter under SEQ_PERF_CNT_EN.
module snn_job_seq #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int PIXEL_BITS = 8,
  parameter int MAX_SPIKES = snn_soc_pkg::MAX_SPIKES,
  parameter int SPIKE_ID_W = 4,
  parameter int TIMEOUT_W  = snn_soc_pkg::SEQ_TIMEOUT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_start,
  input  logic                          job_abort,
  input  logic [ADDR_W-1:0]             job_src_addr,
  input  logic [7:0]                    job_frames,
  input  logic [TIMEOUT_W-1:0]          timeout_cycles,
  output logic                          job_busy,
  output logic                          job_done,
  output logic                          job_err,
  output logic [1:0]                    err_code,
  output logic                          dma_start,
  output logic [ADDR_W-1:0]             dma_src_addr,
  output logic [LEN_W-1:0]              dma_len_words,
  input  logic                          dma_done,
  output logic                          cim_start,
  input  logic                          cim_done,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [SPIKE_ID_W-1:0]         fifo_rd_data,
  output logic                          res_wr_en,
  output logic [$clog2(MAX_SPIKES)-1:0] res_wr_idx,
  output logic [SPIKE_ID_W-1:0]         res_wr_data,
  output logic [$clog2(MAX_SPIKES):0]   res_count,
  output logic [31:0]                   job_cycles
);

  import snn_soc_pkg::*;

  localparam int IDX_W         = $clog2(MAX_SPIKES);
  localparam int CNT_W         = IDX_W + 1;
  localparam int LEN_PER_FRAME = PIXEL_BITS * 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SPIKES);

  seq_state_e              state_q, state_d;
  seq_err_e                err_code_q, err_code_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    job_err_q, job_err_d;
  logic                    dma_start_q, dma_start_d;
  logic                    cim_start_q, cim_start_d;
  logic [ADDR_W-1:0]       src_q, src_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    res_wr_en_q, res_wr_en_d;
  logic [IDX_W-1:0]        res_wr_idx_q, res_wr_idx_d;
  logic [SPIKE_ID_W-1:0]   res_wr_data_q, res_wr_data_d;
  logic [CNT_W-1:0]        res_count_q, res_count_d;

  logic                    rd_en_c;
  logic                    wd_clr;
  logic                    wd_en;
  logic                    wd_expired;
  logic                    start_acc;
  logic [31:0]             len_full;
  logic                    len_sat;
  logic [LEN_W-1:0]        len_words;

  // Word count for the job, saturating to all-ones if it overflows LEN_W.
  always_comb begin
    len_full  = 32'(job_frames) * 32'(LEN_PER_FRAME);
    len_sat   = (len_full >> LEN_W) != 32'd0;
    len_words = len_sat ? '1 : len_full[LEN_W-1:0];
  end

  assign start_acc = (state_q == S_IDLE) && job_start;

  seq_watchdog #(
    .W(TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (timeout_cycles),
    .expired (wd_expired)
  );

  // Sequencer next-state and next-output decode; abort from any active state wins.
  always_comb begin
    state_d       = state_q;
    err_code_d    = err_code_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    job_err_d     = job_err_q;
    dma_start_d   = 1'b0;
    cim_start_d   = 1'b0;
    src_d         = src_q;
    len_d         = len_q;
    res_wr_en_d   = 1'b0;
    res_wr_idx_d  = res_wr_idx_q;
    res_wr_data_d = res_wr_data_q;
    res_count_d   = res_count_q;
    rd_en_c       = 1'b0;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;

    if ((state_q != S_IDLE) && job_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_start) begin
            src_d       = job_src_addr;
            len_d       = len_words;
            job_err_d   = 1'b0;
            err_code_d  = ERR_NONE;
            res_count_d = '0;
            busy_d      = 1'b1;
            state_d     = S_CHECK;
          end
        end
        S_CHECK: begin
          if ((len_q == '0) || (len_q == '1)) begin
            err_code_d = ERR_LEN;
            state_d    = S_DONE;
          end else begin
            state_d = S_DMA_KICK;
          end
        end
        S_DMA_KICK: begin
          dma_start_d = 1'b1;
          wd_clr      = 1'b1;
          state_d     = S_DMA_WAIT;
        end
        S_DMA_WAIT: begin
          wd_en = 1'b1;
          if (dma_done) begin
            state_d = S_CIM_KICK;
          end else if (wd_expired) begin
            err_code_d = ERR_TIMEOUT;
            state_d    = S_DONE;
          end
        end
        S_CIM_KICK: begin
          cim_start_d = 1'b1;
          wd_clr      = 1'b1;
          state_d     = S_CIM_WAIT;
        end
        S_CIM_WAIT: begin
          wd_en = 1'b1;
          if (cim_done) begin
            state_d = S_POP;
          end else if (wd_expired) begin
            err_code_d = ERR_TIMEOUT;
            state_d    = S_DONE;
          end
        end
        S_POP: begin
          if (fifo_empty) begin
            state_d = S_DONE;
          end else begin
            rd_en_c = 1'b1;
            state_d = S_CAP;
          end
        end
        S_CAP: begin
          // Popped data is valid this cycle; overflowing entries are dropped but still drained.
          if (res_count_q < MAX_CNT) begin
            res_wr_en_d   = 1'b1;
            res_wr_idx_d  = res_count_q[IDX_W-1:0];
            res_wr_data_d = fifo_rd_data;
            res_count_d   = res_count_q + 1'b1;
          end else begin
            err_code_d = ERR_OVF;
          end
          state_d = S_POP;
        end
        S_DONE: begin
          done_d    = 1'b1;
          job_err_d = (err_code_q != ERR_NONE);
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      err_code_q    <= ERR_NONE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      job_err_q     <= 1'b0;
      dma_start_q   <= 1'b0;
      cim_start_q   <= 1'b0;
      src_q         <= '0;
      len_q         <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_idx_q  <= '0;
      res_wr_data_q <= '0;
      res_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      job_err_q     <= job_err_d;
      dma_start_q   <= dma_start_d;
      cim_start_q   <= cim_start_d;
      src_q         <= src_d;
      len_q         <= len_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_idx_q  <= res_wr_idx_d;
      res_wr_data_q <= res_wr_data_d;
      res_count_q   <= res_count_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Job duration: cleared on accepted start, counts busy cycles, holds after the job, saturates.
  always_comb begin
    cyc_d = cyc_q;
    if (start_acc) begin
      cyc_d = '0;
    end else if (busy_q && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Duration counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign job_cycles = cyc_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign job_cycles       = 32'd0;
`endif

  assign job_busy      = busy_q;
  assign job_done      = done_q;
  assign job_err       = job_err_q;
  assign err_code      = err_code_q;
  assign dma_start     = dma_start_q;
  assign dma_src_addr  = src_q;
  assign dma_len_words = len_q;
  assign cim_start     = cim_start_q;
  assign fifo_rd_en    = rd_en_c;
  assign res_wr_en     = res_wr_en_q;
  assign res_wr_idx    = res_wr_idx_q;
  assign res_wr_data   = res_wr_data_q;
  assign res_count     = res_count_q;

endmodule

// File: tb/tb_snn_job_seq.sv
module tb_snn_job_seq;

  localparam int LEN_PER_FRAME = 16;
  localparam int RES_DEPTH     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_start, job_abort;
  logic [31:0] job_src_addr;
  logic [7:0]  job_frames;
  logic [19:0] timeout_cycles;
  logic        job_busy, job_done, job_err;
  logic [1:0]  err_code;
  logic        dma_start, dma_done, cim_start, cim_done;
  logic [31:0] dma_src_addr;
  logic [15:0] dma_len_words;
  logic        fifo_empty, fifo_rd_en;
  logic [3:0]  fifo_rd_data;
  logic        res_wr_en;
  logic [3:0]  res_wr_idx, res_wr_data;
  logic [4:0]  res_count;
  logic [31:0] job_cycles;

  logic dma_done_r = 1'b0, dma_done_s = 1'b0;
  logic cim_done_r = 1'b0, cim_done_s = 1'b0;
  assign dma_done = dma_done_r | dma_done_s;
  assign cim_done = cim_done_r | cim_done_s;

  always #5 clk = ~clk;

  snn_job_seq dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_abort(job_abort),
    .job_src_addr(job_src_addr), .job_frames(job_frames), .timeout_cycles(timeout_cycles),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err), .err_code(err_code),
    .dma_start(dma_start), .dma_src_addr(dma_src_addr), .dma_len_words(dma_len_words),
    .dma_done(dma_done), .cim_start(cim_start), .cim_done(cim_done),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .res_wr_en(res_wr_en), .res_wr_idx(res_wr_idx), .res_wr_data(res_wr_data),
    .res_count(res_count), .job_cycles(job_cycles)
  );

  // Scoreboard event kinds: 0 dma_start, 1 cim_start, 2 result write, 3 job_done.
  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } ev_t;

  ev_t  exp_q[$];
  int   fq[$];
  int   ids_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, dma_cyc = 0, done_cyc = 0;
  int   busy_cnt = 0, pops = 0, cim_cnt = 0;
  int   dma_delay = 1, cim_delay = 1;
  bit   dma_hold = 1'b0, cim_hold = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // Reference: what a job should produce, derived from frames, FIFO contents and phase outcomes.
  task automatic model_job(input logic [31:0] src, input int frames, input bit dh, input bit ch, input int tmo);
    int len;
    int n;
    len = frames * LEN_PER_FRAME;
    if (len == 0 || len >= 65535) begin
      push(3, 64'd1, 64'd0, 64'd0);
      return;
    end
    push(0, 64'(src), 64'(len), 64'd0);
    if (dh) begin
      if (tmo != 0) push(3, 64'd2, 64'd0, 64'd0);
      return;
    end
    push(1, 64'd0, 64'd0, 64'd0);
    if (ch) begin
      if (tmo != 0) push(3, 64'd2, 64'd0, 64'd0);
      return;
    end
    n = ids_q.size();
    for (int i = 0; i < n; i++)
      if (i < RES_DEPTH) push(2, 64'(i), 64'(ids_q[i]), 64'd0);
    push(3, (n > RES_DEPTH) ? 64'd3 : 64'd0, 64'(n > RES_DEPTH ? RES_DEPTH : n), 64'(n));
  endtask

  task automatic take(input int kind, input string nm, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.a = '0; e.b = '0; e.c = '0;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected: got event kind %0d expected none", nm, kind);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_order"}, 64'(kind), 64'(e.kind));
      ok = (kind == e.kind);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compare each DUT output event against the next expected one.
  initial forever begin
    ev_t         e;
    bit          ok;
    logic [63:0] exp_cyc;
    @(negedge clk);
    if (rst_n) begin
      if (job_busy) begin
        if (!prev_busy) begin busy_cnt = 0; pops = 0; end
        busy_cnt++;
      end
      prev_busy = job_busy;
      if (fifo_rd_en) pops++;
      if (dma_start) begin
        dma_cyc = cyc;
        take(0, "dma", e, ok);
        if (ok) begin
          chk("dma_src_addr", 64'(dma_src_addr), e.a);
          chk("dma_len_words", 64'(dma_len_words), e.b);
        end
      end
      if (cim_start) begin
        cim_cnt++;
        take(1, "cim", e, ok);
      end
      if (res_wr_en) begin
        take(2, "res", e, ok);
        if (ok) begin
          chk("res_wr_idx", 64'(res_wr_idx), e.a);
          chk("res_wr_data", 64'(res_wr_data), e.b);
        end
      end
      if (job_done) begin
        done_cyc = cyc;
        take(3, "done", e, ok);
        if (ok) begin
`ifdef SEQ_PERF_CNT_EN
          exp_cyc = 64'(busy_cnt);
`else
          exp_cyc = 64'd0;
`endif
          chk("done_err_code", 64'(err_code), e.a);
          chk("done_job_err", 64'(job_err), 64'(e.a != 64'd0));
          chk("done_res_count", 64'(res_count), e.b);
          chk("done_fifo_pops", 64'(pops), e.c);
          chk("done_busy_low", 64'(job_busy), 64'd0);
          chk("done_job_cycles", 64'(job_cycles), exp_cyc);
        end
      end
    end
  end

  // Spike FIFO model: pop on rd_en, data valid in the following cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && fifo_rd_en) begin
      @(posedge clk);
      #1;
      if (fq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fifo_underflow: got pop expected none (empty)");
      end else begin
        fifo_rd_data = 4'(fq.pop_front());
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // DMA responder.
  initial forever begin
    @(negedge clk);
    if (dma_start && !dma_hold) begin
      repeat (dma_delay) @(negedge clk);
      dma_done_r = 1'b1;
      @(negedge clk);
      dma_done_r = 1'b0;
    end
  end

  // CIM responder.
  initial forever begin
    @(negedge clk);
    if (cim_start && !cim_hold) begin
      repeat (cim_delay) @(negedge clk);
      cim_done_r = 1'b1;
      @(negedge clk);
      cim_done_r = 1'b0;
    end
  end

  task automatic start_job(input logic [31:0] src, input int frames, input int dd, input int cd,
                           input bit dh, input bit ch, input int tmo);
    fq = ids_q;
    fifo_empty = (fq.size() == 0);
    dma_delay = dd; cim_delay = cd; dma_hold = dh; cim_hold = ch;
    timeout_cycles = 20'(tmo);
    model_job(src, frames, dh, ch, tmo);
    @(negedge clk);
    job_src_addr = src;
    job_frames = 8'(frames);
    job_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 4000; i++) begin
      if (!job_busy) break;
      @(negedge clk);
    end
    chk({nm, "_idle"}, 64'(job_busy), 64'd0);
    if (job_busy) begin
      job_abort = 1'b1;
      @(negedge clk);
      job_abort = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_cim(input string nm, input int c0);
    for (int i = 0; i < 500; i++) begin
      if (cim_cnt > c0) break;
      @(negedge clk);
    end
    chk({nm, "_cim_seen"}, 64'(cim_cnt > c0), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end expected summary");
    $fatal(1, "bench stalled");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    job_start = 1'b0; job_abort = 1'b0;
    job_src_addr = '0; job_frames = '0; timeout_cycles = '0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(job_busy), 64'd0);
    chk("rst_done", 64'(job_done), 64'd0);
    chk("rst_job_err", 64'(job_err), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_dma_start", 64'(dma_start), 64'd0);
    chk("rst_cim_start", 64'(cim_start), 64'd0);
    chk("rst_res_wr_en", 64'(res_wr_en), 64'd0);
    chk("rst_res_count", 64'(res_count), 64'd0);
    chk("rst_dma_src", 64'(dma_src_addr), 64'd0);
    chk("rst_dma_len", 64'(dma_len_words), 64'd0);
    chk("rst_job_cycles", 64'(job_cycles), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal job.
    ids_q = '{3, 7};
    start_job(32'h0001_0000, 1, 20, 50, 1'b0, 1'b0, 0);
    wait_idle("normal");
    chk("normal_len_latched", 64'(dma_len_words), 64'd16);

    // Zero frames.
    ids_q = '{};
    start_job(32'h0000_1234, 0, 1, 1, 1'b0, 1'b0, 0);
    wait_idle("badlen");
    chk("badlen_latency", 64'((done_cyc - start_cyc) <= 3), 64'd1);
    chk("badlen_job_err_sticky", 64'(job_err), 64'd1);

    // DMA never completes.
    ids_q = '{1};
    start_job(32'h0000_4000, 5, 1, 1, 1'b1, 1'b0, 100);
    wait_idle("timeout");
    chk("timeout_latency", 64'((done_cyc - dma_cyc) >= 95 && (done_cyc - dma_cyc) <= 110), 64'd1);

    // 18 spikes into a 16-entry result buffer.
    ids_q = '{};
    for (int i = 0; i < 18; i++) ids_q.push_back(int'($urandom_range(0, 15)));
    start_job(32'h0002_0000, 3, 5, 10, 1'b0, 1'b0, 0);
    wait_idle("overflow");

    // Abort while waiting for CIM, late cim_done, then a fresh job.
    ids_q = '{1, 2};
    c0 = cim_cnt;
    start_job(32'h0003_0000, 2, 5, 1, 1'b0, 1'b1, 0);
    wait_cim("abort", c0);
    repeat (5) @(negedge clk);
    job_abort = 1'b1;
    @(negedge clk);
    job_abort = 1'b0;
    chk("abort_busy", 64'(job_busy), 64'd0);
    chk("abort_err_code", 64'(err_code), 64'd0);
    chk("abort_job_err", 64'(job_err), 64'd0);
    cim_done_s = 1'b1;
    @(negedge clk);
    cim_done_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_cim_busy", 64'(job_busy), 64'd0);
    chk("abort_leftover", 64'(exp_q.size()), 64'd0);
    ids_q = '{9, 4, 12};
    start_job(32'h0004_0000, 4, 8, 12, 1'b0, 1'b0, 200);
    wait_idle("after_abort");

    // Start while busy and a stray dma_done during CIM_WAIT.
    ids_q = '{5};
    c0 = cim_cnt;
    start_job(32'h0000_A000, 2, 15, 30, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    job_start = 1'b1; job_src_addr = 32'hDEAD_0000; job_frames = 8'd0;
    @(negedge clk);
    job_start = 1'b0;
    wait_cim("stray", c0);
    repeat (5) @(negedge clk);
    dma_done_s = 1'b1;
    @(negedge clk);
    dma_done_s = 1'b0;
    wait_idle("stray");
    chk("stray_src_kept", 64'(dma_src_addr), 64'h0000_A000);

    // Randomised jobs.
    for (int j = 0; j < 24; j++) begin
      int  fr, n, tmo;
      bit  dh, ch;
      fr = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      n  = int'($urandom_range(0, 20));
      ids_q = '{};
      for (int k = 0; k < n; k++) ids_q.push_back(int'($urandom_range(0, 15)));
      dh = ($urandom_range(0, 7) == 0);
      ch = !dh && ($urandom_range(0, 7) == 0);
      tmo = (dh || ch) ? 60 : (($urandom_range(0, 1) == 0) ? 0 : 300);
      start_job($urandom, fr, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), dh, ch, tmo);
      wait_idle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/snn_job_seq.md
Name: snn_job_seq

Overview:
Hardware job sequencer that automates the inference flow: DMA input bit-planes into the input buffer, start CIM inference, then drain the spike output FIFO into a result buffer.
Sits beside the register block. Software writes a job (source address, frame count), pulses start, and waits for a single done/error indication instead of polling DMA and CIM separately.
Sequencer and software never drive DMA/CIM simultaneously: the register block muxes control to this block while job_busy=1.

Parameters:
ADDR_W, 32, source address width
LEN_W, 16, DMA length width in words
PIXEL_BITS, 8, bit-planes per frame; each plane = 2 words (64 inputs)
MAX_SPIKES, 16, result buffer depth
SPIKE_ID_W, 4, spike id width
TIMEOUT_W, 20, watchdog counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
job_start  in  1  single-cycle start pulse; ignored while busy
job_abort  in  1  abort pulse
job_src_addr  in  ADDR_W  data_sram source address
job_frames  in  8  timesteps T
timeout_cycles  in  TIMEOUT_W  per-phase watchdog limit; 0 = disabled
job_busy  out  1  job in progress
job_done  out  1  one-cycle pulse on completion (success or error)
job_err  out  1  sticky error, cleared on next accepted start
err_code  out  2  0 none, 1 bad length, 2 timeout, 3 result overflow
dma_start  out  1  one-cycle DMA start pulse
dma_src_addr  out  ADDR_W  latched source address
dma_len_words  out  LEN_W  latched length
dma_done  in  1  DMA done pulse
cim_start  out  1  one-cycle CIM start pulse
cim_done  in  1  CIM done pulse
fifo_empty  in  1  output FIFO empty
fifo_rd_en  out  1  FIFO pop; data valid the following cycle
fifo_rd_data  in  SPIKE_ID_W  popped spike id
res_wr_en  out  1  result buffer write strobe
res_wr_idx  out  $clog2(MAX_SPIKES)  write index
res_wr_data  out  SPIKE_ID_W  spike id
res_count  out  $clog2(MAX_SPIKES)+1  entries stored in the current job
job_cycles  out  32  job duration counter (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state IDLE; all outputs 0; latched address/length 0.
- States: IDLE, CHECK, DMA_KICK, DMA_WAIT, CIM_KICK, CIM_WAIT, POP, CAP, DONE.
- IDLE, on job_start:
  - latch src and len = job_frames*PIXEL_BITS*2, computed at LEN_W width with saturation to all-ones;
  - clear job_err, err_code, res_count;
  - go to CHECK.
- CHECK: len==0 or saturated -> err_code=1, DONE. Otherwise DMA_KICK.
- DMA_KICK: dma_start=1 for one cycle -> DMA_WAIT.
- DMA_WAIT: dma_done -> CIM_KICK.
- CIM_KICK: cim_start=1 for one cycle -> CIM_WAIT.
- CIM_WAIT: cim_done -> POP.
- dma_done/cim_done arriving in any other state are ignored.
- Watchdog:
  - counter clears on entry to DMA_WAIT and CIM_WAIT;
  - if timeout_cycles!=0 and counter reaches timeout_cycles -> err_code=2, DONE.
- POP:
  - fifo_empty=1 -> DONE;
  - else fifo_rd_en=1 for one cycle -> CAP.
- CAP:
  - res_count<MAX_SPIKES: res_wr_en=1, idx=res_count, data=fifo_rd_data, res_count++;
  - else discard the entry and set err_code=3 (drain continues until empty);
  - -> POP. Throughput is one entry per 2 cycles.
- DONE: job_done=1 for one cycle; job_err=(err_code!=0) -> IDLE.
- job_busy=1 in every state except IDLE; it drops in the same cycle job_done pulses.
- job_abort in any non-IDLE state: go directly to IDLE, no done pulse, no DMA/CIM pulses; job_err and err_code unchanged.
- job_start and job_abort in the same cycle in IDLE: start wins.
- Reset mid-job: immediate IDLE; external DMA/CIM are reset by the same rst_n.

Optional Feature:
SEQ_PERF_CNT_EN:
- Defined: job_cycles clears on accepted start and increments every cycle while job_busy; it holds after done and saturates at all-ones.
- Undefined: job_cycles is tied to 0 and no counter is instantiated.

Decomposition:
- snn_soc_pkg gets: seq_state_e enum; seq_err_e (ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_OVF); MAX_SPIKES and SEQ_TIMEOUT_W constants.
- Sub-module seq_watchdog: loadable counter with clear, enable, limit and expired outputs.

Test Plan:
- Normal job: frames=1, src=0x0001_0000, DMA done after 20 cycles, CIM done after 50, FIFO holds ids {3,7} -> dma_len_words=16; res writes (0,3),(1,7); res_count=2; job_done pulse; job_err=0.
- Bad length: frames=0 -> no dma_start, job_done within 3 cycles, err_code=1.
- Timeout: timeout_cycles=100, dma_done withheld -> job_done at ~100 cycles after DMA_WAIT entry, err_code=2, cim_start never asserted.
- Overflow: FIFO holds 18 ids -> 16 res writes, 18 fifo_rd_en pulses, err_code=3, res_count=16.
- Abort during CIM_WAIT, then a new start -> busy drops with no done pulse; the second job completes normally and a late cim_done from the aborted job is ignored in IDLE.
- Start while busy, and stray dma_done during CIM_WAIT -> both ignored; with SEQ_PERF_CNT_EN defined, job_cycles equals the busy duration.
